// File: rtl/data_ram_arbiter.sv
// Arbiter sharing a single-port data RAM between the CPU and a debug/loader port.
// CPU has fixed priority; a starvation counter forces a debug grant after STARVE_LIMIT CPU wins.
module data_ram_arbiter #(
  parameter int unsigned AW           = 16,
  parameter int unsigned DW           = 16,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_done,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;

  state_t     state_reg, state_next;
  logic       owner_dbg_reg, owner_dbg_next;
  logic [3:0] starve_cnt_reg, starve_cnt_next;
  logic       we_reg;
  logic       any_req;
  logic       pick_dbg;
  logic       busy;

  assign any_req  = cpu_req | dbg_req;
  // Debug wins when alone, or when the CPU has already been favoured STARVE_LIMIT times.
  assign pick_dbg = dbg_req & (~cpu_req | (32'(starve_cnt_reg) >= STARVE_LIMIT));

  always_comb begin
    state_next      = state_reg;
    owner_dbg_next  = owner_dbg_reg;
    starve_cnt_next = starve_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next     = ISSUE;
          owner_dbg_next = pick_dbg;
        end
        if (!dbg_req || pick_dbg) begin
          starve_cnt_next = 4'd0;
        end else if (starve_cnt_reg != 4'hF) begin
          starve_cnt_next = starve_cnt_reg + 4'd1;
        end
      end
      ISSUE:   state_next = RESP;
      RESP:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      owner_dbg_reg  <= 1'b0;
      starve_cnt_reg <= 4'd0;
      we_reg         <= 1'b0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
      cpu_rdata      <= '0;
      dbg_rdata      <= '0;
    end else begin
      state_reg      <= state_next;
      owner_dbg_reg  <= owner_dbg_next;
      starve_cnt_reg <= starve_cnt_next;
      if (state_reg == IDLE && any_req) begin
        ram_addr  <= pick_dbg ? dbg_addr  : cpu_addr;
        ram_wdata <= pick_dbg ? dbg_wdata : cpu_wdata;
        we_reg    <= pick_dbg ? dbg_we    : cpu_we;
      end
      // RAM q is valid during RESP; only reads update the owner's data register.
      if (state_reg == RESP && !we_reg) begin
        if (owner_dbg_reg) dbg_rdata <= ram_rdata;
        else               cpu_rdata <= ram_rdata;
      end
    end
  end

  assign busy      = (state_reg != IDLE);
  assign cpu_gnt   = busy & ~owner_dbg_reg;
  assign dbg_gnt   = busy &  owner_dbg_reg;
  assign ram_we    = (state_reg == ISSUE) & we_reg;
  assign cpu_done  = (state_reg == DONE) & ~owner_dbg_reg;
  assign dbg_done  = (state_reg == DONE) &  owner_dbg_reg;
  assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter: RAM model with registered address, two DUTs
// (starvation limit 3 and 0) driven cycle by cycle.
module tb_data_ram_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_gnt, cpu_done, cpu_stall, dbg_gnt, dbg_done, ram_we;
  logic [15:0] cpu_rdata, dbg_rdata, ram_addr, ram_wdata, ram_rdata;

  logic        z_cpu_req, z_dbg_req;
  logic        z_cpu_gnt, z_cpu_done, z_cpu_stall, z_dbg_gnt, z_dbg_done, z_ram_we;
  logic [15:0] z_cpu_rdata, z_dbg_rdata, z_ram_addr, z_ram_wdata;

  logic [15:0] mem [0:255];
  logic [15:0] addr_q;

  int n_assert = 0;
  int n_fail   = 0;

  data_ram_arbiter #(.AW(16), .DW(16), .STARVE_LIMIT(3)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  data_ram_arbiter #(.AW(16), .DW(16), .STARVE_LIMIT(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .cpu_req(z_cpu_req), .cpu_we(1'b1), .cpu_addr(16'h0100), .cpu_wdata(16'h00C0),
    .cpu_gnt(z_cpu_gnt), .cpu_done(z_cpu_done), .cpu_rdata(z_cpu_rdata), .cpu_stall(z_cpu_stall),
    .dbg_req(z_dbg_req), .dbg_we(1'b1), .dbg_addr(16'h0200), .dbg_wdata(16'h00D0),
    .dbg_gnt(z_dbg_gnt), .dbg_done(z_dbg_done), .dbg_rdata(z_dbg_rdata),
    .ram_addr(z_ram_addr), .ram_wdata(z_ram_wdata), .ram_we(z_ram_we), .ram_rdata(16'h0000)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: address registered at the clock edge, q read combinationally.
  always @(posedge clk) begin
    addr_q <= ram_addr;
    if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
  end
  assign ram_rdata = mem[addr_q[7:0]];

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // One full access on the limit-3 DUT by one requester; checks done timing and returns rdata.
  task automatic access(input logic is_dbg, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, output logic [15:0] rdata);
    next_cyc;
    if (is_dbg) begin dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; end
    else        begin cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
    next_cyc; mid;
    chk1("acc_issue_we", ram_we, we);
    chk16("acc_issue_addr", ram_addr, addr);
    next_cyc; next_cyc; mid;
    chk1("acc_done", is_dbg ? dbg_done : cpu_done, 1'b1);
    rdata = is_dbg ? dbg_rdata : cpu_rdata;
    $display("txn %s %s addr=0x%04h wdata=0x%04h rdata=0x%04h", is_dbg ? "dbg" : "cpu",
             we ? "wr" : "rd", addr, wdata, rdata);
    if (is_dbg) dbg_req = 1'b0; else cpu_req = 1'b0;
  endtask

  logic [15:0] rd;
  logic        exp_dbg;

  initial begin
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    z_cpu_req = 0; z_dbg_req = 0;

    // Reset state
    repeat (2) next_cyc;
    mid;
    chk1("rst_ram_we", ram_we, 1'b0);
    chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk1("rst_dbg_gnt", dbg_gnt, 1'b0);
    chk1("rst_cpu_done", cpu_done, 1'b0);
    chk16("rst_ram_addr", ram_addr, 16'h0000);
    chk16("rst_ram_wdata", ram_wdata, 16'h0000);
    chk16("rst_cpu_rdata", cpu_rdata, 16'h0000);
    chk16("rst_dbg_rdata", dbg_rdata, 16'h0000);
    next_cyc;
    reset = 1'b1;

    // Test 1: CPU write 0x0010 = 0xBEEF, cycle-by-cycle
    next_cyc;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
    mid;
    chk1("t1_n_stall", cpu_stall, 1'b1);
    chk1("t1_n_we", ram_we, 1'b0);
    chk1("t1_n_gnt", cpu_gnt, 1'b0);
    next_cyc; mid;
    chk1("t1_n1_we", ram_we, 1'b1);
    chk1("t1_n1_gnt", cpu_gnt, 1'b1);
    chk16("t1_n1_addr", ram_addr, 16'h0010);
    chk16("t1_n1_wdata", ram_wdata, 16'hBEEF);
    chk1("t1_n1_stall", cpu_stall, 1'b1);
    next_cyc; mid;
    chk1("t1_n2_we", ram_we, 1'b0);
    chk1("t1_n2_stall", cpu_stall, 1'b1);
    chk1("t1_n2_done", cpu_done, 1'b0);
    next_cyc; mid;
    chk1("t1_n3_done", cpu_done, 1'b1);
    chk1("t1_n3_stall", cpu_stall, 1'b0);
    chk1("t1_n3_we", ram_we, 1'b0);
    $display("txn cpu wr addr=0x0010 wdata=0xbeef");
    cpu_req = 0; cpu_we = 0;
    next_cyc; mid;
    chk1("t1_n4_done", cpu_done, 1'b0);
    chk1("t1_n4_gnt", cpu_gnt, 1'b0);

    // Test 2: CPU read back 0x0010
    next_cyc;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    next_cyc; next_cyc; mid;
    chk16("t2_n2_rdata_old", cpu_rdata, 16'h0000);
    next_cyc; mid;
    chk1("t2_n3_done", cpu_done, 1'b1);
    chk16("t2_cpu_rdata", cpu_rdata, 16'hBEEF);
    chk16("t2_dbg_rdata", dbg_rdata, 16'h0000);
    $display("txn cpu rd addr=0x0010 rdata=0x%04h", cpu_rdata);
    cpu_req = 0;

    // Test 3: both held, limit 3 -> CPU, CPU, CPU, DBG, CPU
    next_cyc;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0010;
    mid;
    chk1("t3_idle_gnt", cpu_gnt | dbg_gnt, 1'b0);
    for (int k = 0; k < 5; k++) begin
      exp_dbg = (k == 3);
      next_cyc; mid;
      chk1("t3_cpu_gnt", cpu_gnt, ~exp_dbg);
      chk1("t3_dbg_gnt", dbg_gnt, exp_dbg);
      next_cyc; next_cyc; mid;
      chk1("t3_cpu_done", cpu_done, ~exp_dbg);
      chk1("t3_dbg_done", dbg_done, exp_dbg);
      $display("txn slot %0d owner=%s", k, exp_dbg ? "dbg" : "cpu");
      if (k == 3) chk16("t3_dbg_rdata", dbg_rdata, 16'hBEEF);
      next_cyc; mid;
      chk1("t3_gap_gnt", cpu_gnt | dbg_gnt, 1'b0);
    end
    cpu_req = 0; dbg_req = 0;
    next_cyc; mid;
    chk1("t3_quiet_gnt", cpu_gnt | dbg_gnt, 1'b0);

    // Test 4: STARVE_LIMIT=0, simultaneous request -> debug first, CPU done 4 cycles later
    next_cyc;
    z_cpu_req = 1; z_dbg_req = 1;
    next_cyc; mid;
    chk1("t4_dbg_gnt", z_dbg_gnt, 1'b1);
    chk1("t4_cpu_gnt", z_cpu_gnt, 1'b0);
    chk16("t4_ram_addr", z_ram_addr, 16'h0200);
    next_cyc; next_cyc; mid;
    chk1("t4_dbg_done", z_dbg_done, 1'b1);
    $display("txn dut0 dbg wr addr=0x0200");
    z_dbg_req = 0;
    for (int c = 1; c <= 4; c++) begin
      next_cyc; mid;
      chk1("t4_cpu_done_timing", z_cpu_done, (c == 4) ? 1'b1 : 1'b0);
    end
    chk16("t4_cpu_wdata", z_ram_wdata, 16'h00C0);
    $display("txn dut0 cpu wr addr=0x0100");
    z_cpu_req = 0;

    // Test 5: debug loader writes 0..3 = 1..4, CPU reads 0x0003 with addr changed in ISSUE
    for (int i = 0; i < 4; i++) begin
      access(1'b1, 1'b1, 16'(i), 16'(i + 1), rd);
    end
    chk16("t5_dbg_rdata_kept", dbg_rdata, 16'hBEEF);
    next_cyc;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0003;
    next_cyc;
    cpu_addr = 16'h0010;
    mid;
    chk16("t5_latched_addr", ram_addr, 16'h0003);
    next_cyc; next_cyc; mid;
    chk1("t5_done", cpu_done, 1'b1);
    chk16("t5_cpu_rdata", cpu_rdata, 16'h0004);
    $display("txn cpu rd addr=0x0003 rdata=0x%04h", cpu_rdata);
    cpu_req = 0;

    // Test 6: reset during ISSUE of a CPU write aborts it
    access(1'b0, 1'b1, 16'h0020, 16'h1111, rd);
    next_cyc;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
    next_cyc; mid;
    chk1("t6_issue_we", ram_we, 1'b1);
    reset = 1'b0;
    #1;
    chk1("t6_we_dropped", ram_we, 1'b0);
    chk1("t6_gnt_dropped", cpu_gnt, 1'b0);
    cpu_req = 0;
    for (int c = 0; c < 3; c++) begin
      next_cyc; mid;
      chk1("t6_no_done", cpu_done, 1'b0);
    end
    reset = 1'b1;
    access(1'b0, 1'b0, 16'h0020, 16'h0000, rd);
    chk16("t6_old_value", rd, 16'h1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
